// File: rtl/csa_seq_adder.sv
// csa_seq_adder: byte-serial add/subtract sequencer.
// A WORDS-byte add or subtract is run through one shared 8-bit adder slice with
// carry-in. The slice handles one byte per clock, starting with the LSB byte.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only while idle
//   sub   - 0: a+b, 1: a-b (sampled with start)
//   a, b  - W-bit operands (sampled with start)
//   busy  - operation in progress (WORDS cycles)
//   done  - one-cycle pulse; sum/carry updated on the same edge
//   sum   - W-bit result, held stable between done pulses
//   carry - final carry-out (for sub: 1 = no borrow)
module csa_seq_adder #(
    parameter int WORDS = 4,
    localparam int W    = 8 * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            cf_q, cf_d;
    logic            carry_q, carry_d;
    logic            done_q, done_d;

    logic [7:0] a_byte, b_byte;
    logic [8:0] slice;

    // Byte select by index. A compare-per-byte mux keeps every part-select
    // constant, so no out-of-range selects appear for small WORDS.
    always_comb begin
        a_byte = 8'd0;
        b_byte = 8'd0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_byte = op_a_q[i*8 +: 8];
                b_byte = op_b_q[i*8 +: 8];
            end
        end
        slice = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, cf_q};
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cf_d    = cf_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    // Subtract is a + ~b + 1; the +1 enters as the first carry-in.
                    op_b_d  = sub ? ~b : b;
                    cf_d    = sub;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDXW'(i)) work_d[i*8 +: 8] = slice[7:0];
                end
                cf_d  = slice[8];
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST) begin
                    // Publish the whole word at once so partial results never show.
                    sum_d   = work_d;
                    carry_d = slice[8];
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cf_q    <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cf_q    <= cf_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    // busy comes straight from the state so an async reset drops it immediately.
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Testbench for csa_seq_adder (WORDS=4). The driver pushes the expected
// {carry,sum} into a queue when it issues a request; the monitor pops and
// compares on every done pulse.
module tb_csa_seq_adder;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry;
    logic [W-1:0] sum;

    csa_seq_adder #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [W:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on done, single-cycle done, sum stability.
    logic [W-1:0] prev_sum = '0;
    logic         prev_done = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done) begin
                    done_cnt++;
                    chk("busy_low_at_done", 64'(busy), 64'd0);
                    chk("done_single_pulse", 64'(prev_done), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        logic [W:0] e;
                        e = exp_q.pop_front();
                        chk("sum", 64'(sum), 64'(e[W-1:0]));
                        chk("carry", 64'(carry), 64'(e[W]));
                    end
                end else begin
                    chk("sum_stable", 64'(sum), 64'(prev_sum));
                end
            end
            prev_sum  = sum;
            prev_done = done;
        end
    end

    // Issue one request and wait (bounded) for its done, counting busy cycles.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input logic [W-1:0] es, input logic ec);
        int  bcnt;
        bit  got;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        exp_q.push_back({ec, es});
        @(negedge clk);
        start = 1'b0;
        bcnt = 0; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (done) got = 1;
            else if (busy) bcnt++;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("busy_cycles", 64'(bcnt), 64'(WORDS));
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk(name, 64'(got), 64'd1);
    endtask

    initial begin
        int d0;
        // 1. reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);

        // 2-4. basic add/sub vectors
        run_op(32'h00000002, 32'h00000001, 1'b0, 32'h00000003, 1'b0);
        run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        run_op(32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1);
        run_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0);

        // 5. start while busy ignored; start in done cycle accepted
        d0 = done_cnt;
        @(negedge clk);
        a = 32'h000000F0; b = 32'h00000001; sub = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 32'h000000F1});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        wait_done("done_first_of_pair");
        a = 32'h11111111; b = 32'h22222222; sub = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 32'h33333333});
        @(negedge clk);
        start = 1'b0;
        wait_done("done_back_to_back");
        @(negedge clk);
        chk("pair_done_count", 64'(done_cnt - d0), 64'd2);

        // 6. async reset mid-operation
        d0 = done_cnt;
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_sum", 64'(sum), 64'd0);
        chk("async_rst_carry", 64'(carry), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        run_op(32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
